// File: rtl/scc68070_timer_unit.sv
// ---------------------------------------------------------------------------
// scc68070_timer_unit
// Prescaled timer/counter peripheral for the SCC68070 SoC wrapper.
// Channel 0 is a free-running reload timer. Channels 1..NUM_CHANNELS-1
// support match, capture and event-count modes. Status is write-1-to-clear,
// and irq is a registered OR of the status flags.
//
// Ports:
//   clk           system clock
//   nReset        asynchronous active-low reset
//   cs            register window select
//   addr[2:0]     register index (A[3:1])
//   uds / lds     upper / lower byte strobes, active-high
//   write_strobe  1 = write, 0 = read
//   data_in[15:0] CPU write data
//   data_out[15:0] combinational read data, 0 when not reading
//   bus_ack       equals cs (zero wait states)
//   t_in[2:0]     async event/capture pins for channels 1..2 (bit 0 unused)
//   irq           level interrupt request
// ---------------------------------------------------------------------------
module scc68070_timer_unit #(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned PRESCALE_DIV = 96
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        cs,
    input  logic [2:0]  addr,
    input  logic        uds,
    input  logic        lds,
    input  logic        write_strobe,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        bus_ack,
    input  logic [2:0]  t_in,
    output logic        irq
);

    localparam int unsigned PW         = $clog2(PRESCALE_DIV);
    localparam logic [PW-1:0] PLAST    = PW'(PRESCALE_DIV - 1);
    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam bit IMPL1               = (NUM_CHANNELS > 1);
    localparam bit IMPL2               = (NUM_CHANNELS > 2);
    localparam logic [7:0] STAT_MASK   = 8'h80 | (IMPL1 ? 8'h70 : 8'h00)
                                               | (IMPL2 ? 8'h0E : 8'h00);
    localparam logic [7:0] CTRL_MASK   = (IMPL1 ? 8'hF0 : 8'h00)
                                       | (IMPL2 ? 8'h0F : 8'h00);

    // Byte-lane merge of a CPU write into a WIDTH-bit register
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old,
        input logic             hi,
        input logic             lo,
        input logic [15:0]      d
    );
        logic [15:0] v;
        v = 16'(old);
        if (hi) v[15:8] = d[15:8];
        if (lo) v[7:0]  = d[7:0];
        return WIDTH'(v);
    endfunction

    // Next counter value and {ma, cap, ov} flags for one mode channel
    function automatic logic [WIDTH+2:0] chan_next(
        input logic [WIDTH-1:0] cnt,
        input logic [1:0]       mode,
        input logic [1:0]       evsel,
        input logic             tick,
        input logic             rise,
        input logic             fall,
        input logic [WIDTH-1:0] reload,
        input logic [WIDTH-1:0] t0
    );
        logic [WIDTH-1:0] n;
        logic             ma;
        logic             cap;
        logic             ov;
        logic             ev;
        n   = cnt;
        ma  = 1'b0;
        cap = 1'b0;
        ov  = 1'b0;
        ev  = (evsel[0] & rise) | (evsel[1] & fall);
        case (mode)
            2'b01: begin
                if (tick) begin
                    if (cnt == MAX) begin
                        n  = '0;
                        ov = 1'b1;
                    end else begin
                        n = cnt + WIDTH'(1);
                    end
                    ma = (n == reload);
                end
            end
            2'b10: begin
                if (ev) begin
                    n   = t0;
                    cap = 1'b1;
                end
            end
            2'b11: begin
                if (ev) begin
                    if (cnt == MAX) begin
                        n  = '0;
                        ov = 1'b1;
                    end else begin
                        n = cnt + WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
        return {ma, cap, ov, n};
    endfunction

    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_t0;
    logic [WIDTH-1:0] r_t1;
    logic [WIDTH-1:0] r_t2;
    logic [WIDTH-1:0] r_reload;
    logic [7:0]       r_ctrl;
    logic [7:0]       r_status;
    logic [2:1]       r_sync1;
    logic [2:1]       r_sync2;
    logic [2:1]       r_tin_q;
    logic             r_irq;

    logic             w_tick;
    logic             w_wr;
    logic             w_wr_any;
    logic             w_wr_t0;
    logic             w_wr_t1;
    logic             w_wr_t2;
    logic             w_wr_reload;
    logic             w_wr_stat;
    logic             w_wr_ctrl;
    logic [2:1]       w_rise;
    logic [2:1]       w_fall;
    logic [WIDTH+2:0] w_c1;
    logic [WIDTH+2:0] w_c2;
    logic [2:0]       w_c1_f;
    logic [2:0]       w_c2_f;
    logic [WIDTH-1:0] w_t0_nxt;
    logic             w_t0_ov;
    logic [WIDTH-1:0] w_t1_nxt;
    logic [WIDTH-1:0] w_t2_nxt;
    logic [7:0]       w_status_nxt;
    logic             w_unused;

    assign w_unused = t_in[0];

    // Time base and write decode
    assign w_tick      = (r_presc == PLAST);
    assign w_wr        = cs & write_strobe;
    assign w_wr_any    = w_wr & (uds | lds);
    assign w_wr_reload = w_wr_any & (addr == 3'd1);
    assign w_wr_t0     = w_wr_any & (addr == 3'd2);
    assign w_wr_t1     = w_wr_any & (addr == 3'd3);
    assign w_wr_t2     = w_wr_any & (addr == 3'd4);
    assign w_wr_stat   = w_wr & uds & (addr == 3'd0);
    assign w_wr_ctrl   = w_wr & lds & (addr == 3'd0);

    // Edge detector on the synchronised pins
    assign w_rise = r_sync2 & ~r_tin_q;
    assign w_fall = ~r_sync2 & r_tin_q;

    assign w_c1 = chan_next(r_t1, r_ctrl[5:4], r_ctrl[7:6], w_tick,
                            w_rise[1], w_fall[1], r_reload, r_t0);
    assign w_c2 = chan_next(r_t2, r_ctrl[1:0], r_ctrl[3:2], w_tick,
                            w_rise[2], w_fall[2], r_reload, r_t0);

    // Counter next state; a CPU write wins and swallows that cycle's tick/edge
    always_comb begin
        w_t0_nxt = r_t0;
        w_t0_ov  = 1'b0;
        w_t1_nxt = '0;
        w_t2_nxt = '0;
        w_c1_f   = 3'b000;
        w_c2_f   = 3'b000;
        if (w_wr_t0) begin
            w_t0_nxt = merge_bytes(r_t0, uds, lds, data_in);
        end else if (w_tick) begin
            if (r_t0 == MAX) begin
                w_t0_nxt = r_reload;
                w_t0_ov  = 1'b1;
            end else begin
                w_t0_nxt = r_t0 + WIDTH'(1);
            end
        end
        if (IMPL1) begin
            if (w_wr_t1) begin
                w_t1_nxt = merge_bytes(r_t1, uds, lds, data_in);
            end else begin
                w_t1_nxt = w_c1[WIDTH-1:0];
                w_c1_f   = w_c1[WIDTH+2:WIDTH];
            end
        end
        if (IMPL2) begin
            if (w_wr_t2) begin
                w_t2_nxt = merge_bytes(r_t2, uds, lds, data_in);
            end else begin
                w_t2_nxt = w_c2[WIDTH-1:0];
                w_c2_f   = w_c2[WIDTH+2:WIDTH];
            end
        end
    end

    // Status: new flags take priority over a same-cycle write-1 clear
    always_comb begin
        w_status_nxt = r_status;
        if (w_wr_stat) begin
            w_status_nxt = r_status & ~data_in[15:8];
        end
        w_status_nxt = (w_status_nxt | {w_t0_ov, w_c1_f, w_c2_f, 1'b0}) & STAT_MASK;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_presc  <= '0;
            r_t0     <= '0;
            r_t1     <= '0;
            r_t2     <= '0;
            r_reload <= '0;
            r_ctrl   <= '0;
            r_status <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_tin_q  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_presc  <= w_tick ? '0 : r_presc + PW'(1);
            r_sync1  <= t_in[2:1];
            r_sync2  <= r_sync1;
            r_tin_q  <= r_sync2;
            if (w_wr_reload) begin
                r_reload <= merge_bytes(r_reload, uds, lds, data_in);
            end
            if (w_wr_ctrl) begin
                r_ctrl <= data_in[7:0] & CTRL_MASK;
            end
            r_t0     <= w_t0_nxt;
            r_t1     <= w_t1_nxt;
            r_t2     <= w_t2_nxt;
            r_status <= w_status_nxt;
            r_irq    <= |r_status;
        end
    end

    // Combinational read mux
    always_comb begin
        data_out = 16'h0000;
        if (cs && !write_strobe) begin
            case (addr)
                3'd0:    data_out = {r_status, r_ctrl};
                3'd1:    data_out = 16'(r_reload);
                3'd2:    data_out = 16'(r_t0);
                3'd3:    data_out = 16'(r_t1);
                3'd4:    data_out = 16'(r_t2);
                default: data_out = 16'h0000;
            endcase
        end
    end

    assign bus_ack = cs;
    assign irq     = r_irq;

endmodule

// File: tb/tb_scc68070_timer_unit.sv
// ---------------------------------------------------------------------------
// tb_scc68070_timer_unit
// Directed bench for scc68070_timer_unit. A 16-bit/3-channel instance and an
// 8-bit/1-channel instance share all inputs. Expected read data is queued
// when a read is driven and popped when data_out is sampled. A small model
// of the prescaler and timer0 supplies tick timing and capture values.
// ---------------------------------------------------------------------------
module tb_scc68070_timer_unit;

    logic        clk;
    logic        nReset;
    logic        cs;
    logic [2:0]  addr;
    logic        uds;
    logic        lds;
    logic        write_strobe;
    logic [15:0] data_in;
    logic [2:0]  t_in;
    logic [15:0] data_out;
    logic        bus_ack;
    logic        irq;
    logic [15:0] data_out8;
    logic        bus_ack8;
    logic        irq8;

    int checks;
    int failures;
    logic [15:0] exp_q[$];

    scc68070_timer_unit #(.NUM_CHANNELS(3), .WIDTH(16), .PRESCALE_DIV(4)) dut (
        .clk(clk), .nReset(nReset), .cs(cs), .addr(addr), .uds(uds), .lds(lds),
        .write_strobe(write_strobe), .data_in(data_in), .data_out(data_out),
        .bus_ack(bus_ack), .t_in(t_in), .irq(irq)
    );

    scc68070_timer_unit #(.NUM_CHANNELS(1), .WIDTH(8), .PRESCALE_DIV(4)) dut8 (
        .clk(clk), .nReset(nReset), .cs(cs), .addr(addr), .uds(uds), .lds(lds),
        .write_strobe(write_strobe), .data_in(data_in), .data_out(data_out8),
        .bus_ack(bus_ack8), .t_in(t_in), .irq(irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: prescaler, tick count, reload and timer0 (16-bit)
    logic [1:0]  m_presc;
    logic [15:0] m_t0;
    logic [15:0] m_reload;
    int          m_ticks;

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_presc  <= 2'd0;
            m_t0     <= 16'h0000;
            m_reload <= 16'h0000;
            m_ticks  <= 0;
        end else begin
            m_presc <= (m_presc == 2'd3) ? 2'd0 : m_presc + 2'd1;
            if (m_presc == 2'd3) m_ticks <= m_ticks + 1;
            if (cs && write_strobe && addr == 3'd1) begin
                if (uds) m_reload[15:8] <= data_in[15:8];
                if (lds) m_reload[7:0]  <= data_in[7:0];
            end
            if (cs && write_strobe && addr == 3'd2 && (uds || lds)) begin
                if (uds) m_t0[15:8] <= data_in[15:8];
                if (lds) m_t0[7:0]  <= data_in[7:0];
            end else if (m_presc == 2'd3) begin
                m_t0 <= (m_t0 == 16'hFFFF) ? m_reload : m_t0 + 16'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a write now (called at a negedge); it lands on the next posedge
    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic u, input logic l);
        cs = 1'b1; write_strobe = 1'b1; addr = a; data_in = d; uds = u; lds = l;
        @(negedge clk);
        cs = 1'b0; write_strobe = 1'b0; uds = 1'b0; lds = 1'b0;
    endtask

    // Read one register of either instance and compare the masked value
    task automatic rd_chk(input bit sel8, input logic [2:0] a, input logic [15:0] mask,
                          input logic [15:0] exp, input string tag);
        logic [15:0] obs;
        logic [15:0] e;
        exp_q.push_back(exp & mask);
        cs = 1'b1; write_strobe = 1'b0; addr = a; uds = 1'b1; lds = 1'b1;
        #1;
        obs = (sel8 ? data_out8 : data_out) & mask;
        e = exp_q.pop_front();
        chk(tag, obs, e);
        cs = 1'b0; uds = 1'b0; lds = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int tgt;
        int guard;
        tgt = m_ticks + n;
        guard = 0;
        while (m_ticks < tgt && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (m_ticks < tgt) begin
            checks++;
            failures++;
            $error("FAIL tick_wait observed=%0d expected=%0d", m_ticks, tgt);
        end
    endtask

    initial begin
        logic [15:0] cap_exp;
        int guard;
        checks = 0; failures = 0;
        nReset = 1'b0; cs = 1'b0; addr = 3'd0; uds = 1'b0; lds = 1'b0;
        write_strobe = 1'b0; data_in = 16'h0000; t_in = 3'b000;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_irq", 16'(irq), 16'h0000);
        chk("rst_irq8", 16'(irq8), 16'h0000);
        chk("rst_ack_idle", 16'(bus_ack), 16'h0000);
        chk("rst_dout_idle", data_out, 16'h0000);
        cs = 1'b1; #1;
        chk("ack_eq_cs", 16'(bus_ack), 16'h0001);
        chk("ack8_eq_cs", 16'(bus_ack8), 16'h0001);
        cs = 1'b0;
        rd_chk(0, 3'd0, 16'hFFFF, 16'h0000, "rst_stat_ctrl");
        rd_chk(0, 3'd2, 16'hFFFF, 16'h0000, "rst_t0");
        @(negedge clk);
        nReset = 1'b1;

        // Timer0 reload and overflow, irq latency, write-1 clear
        wr(3'd1, 16'hFFF0, 1, 1);
        wr(3'd2, 16'hFFFE, 1, 1);
        wait_ticks(1);
        rd_chk(0, 3'd2, 16'hFFFF, 16'hFFFF, "t0_first_tick");
        wait_ticks(1);
        rd_chk(0, 3'd2, 16'hFFFF, 16'hFFF0, "t0_reload");
        rd_chk(0, 3'd0, 16'h8000, 16'h8000, "t0_ov_set");
        chk("irq_not_yet", 16'(irq), 16'h0000);
        @(negedge clk);
        chk("irq_set", 16'(irq), 16'h0001);
        wr(3'd0, 16'h8000, 1, 0);
        rd_chk(0, 3'd0, 16'h8000, 16'h0000, "t0_ov_clr");
        chk("irq_hold", 16'(irq), 16'h0001);
        @(negedge clk);
        chk("irq_drop", 16'(irq), 16'h0000);

        // Channel 1 match mode
        wr(3'd2, 16'h0000, 1, 1);
        wr(3'd1, 16'h0005, 1, 1);
        wr(3'd3, 16'h0003, 1, 1);
        wr(3'd0, 16'h0010, 0, 1);
        wait_ticks(1);
        rd_chk(0, 3'd3, 16'hFFFF, 16'h0004, "t1_match_step1");
        rd_chk(0, 3'd0, 16'h4000, 16'h0000, "t1_ma_early");
        wait_ticks(1);
        rd_chk(0, 3'd3, 16'hFFFF, 16'h0005, "t1_match_step2");
        rd_chk(0, 3'd0, 16'h7000, 16'h4000, "t1_ma_set");
        wait_ticks(1);
        rd_chk(0, 3'd3, 16'hFFFF, 16'h0006, "t1_match_cont");

        // Channel 2 capture on rising edge of t_in[2]
        wr(3'd0, 16'h0016, 0, 1);
        t_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        cap_exp = m_t0;
        @(negedge clk);
        rd_chk(0, 3'd4, 16'hFFFF, cap_exp, "t2_capture");
        rd_chk(0, 3'd0, 16'h0400, 16'h0400, "t2_cap_set");
        t_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        rd_chk(0, 3'd4, 16'hFFFF, cap_exp, "t2_no_fall_cap");

        // Channel 1 event count on both edges
        wr(3'd0, 16'hFFF0, 1, 1);
        wr(3'd3, 16'hFFFE, 1, 1);
        rd_chk(0, 3'd0, 16'h1000, 16'h0000, "t1_ov_clear");
        t_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        rd_chk(0, 3'd3, 16'hFFFF, 16'hFFFF, "t1_ev_rise");
        rd_chk(0, 3'd0, 16'h1000, 16'h0000, "t1_ov_early");
        t_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        rd_chk(0, 3'd3, 16'hFFFF, 16'h0000, "t1_ev_wrap");
        rd_chk(0, 3'd0, 16'h1000, 16'h1000, "t1_ov_set");
        wait_ticks(2);
        rd_chk(0, 3'd3, 16'hFFFF, 16'h0000, "t1_ev_ignores_tick");

        // Byte lanes, narrow width, unimplemented channels, empty index
        wr(3'd2, 16'h1200, 1, 1);
        wr(3'd2, 16'hABCD, 0, 1);
        rd_chk(0, 3'd2, 16'hFFFF, 16'h12CD, "t0_lds_only");
        wr(3'd2, 16'hFFFF, 1, 1);
        rd_chk(1, 3'd2, 16'hFFFF, 16'h00FF, "w8_t0");
        rd_chk(0, 3'd2, 16'hFFFF, 16'hFFFF, "w16_t0");
        wr(3'd1, 16'hABCD, 1, 1);
        rd_chk(1, 3'd1, 16'hFFFF, 16'h00CD, "w8_reload");
        rd_chk(1, 3'd3, 16'hFFFF, 16'h0000, "w8_t1_absent");
        rd_chk(1, 3'd0, 16'h00FF, 16'h0000, "w8_ctrl_absent");
        wr(3'd6, 16'h5A5A, 1, 1);
        rd_chk(0, 3'd6, 16'hFFFF, 16'h0000, "idx6_zero");
        rd_chk(1, 3'd6, 16'hFFFF, 16'h0000, "idx6_zero_w8");

        // Overflow flag set in the same cycle as its write-1 clear
        wr(3'd2, 16'h0000, 1, 1);
        wr(3'd0, 16'hFF00, 1, 0);
        wr(3'd2, 16'hFFFF, 1, 1);
        guard = 0;
        while (m_presc != 2'd3 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        wr(3'd0, 16'h8000, 1, 0);
        rd_chk(0, 3'd0, 16'h8000, 16'h8000, "set_beats_clear");
        chk("irq_pre_conflict", 16'(irq), 16'h0000);
        @(negedge clk);
        chk("irq_after_conflict", 16'(irq), 16'h0001);

        // Asynchronous reset mid-count
        nReset = 1'b0;
        #1;
        chk("arst_irq", 16'(irq), 16'h0000);
        rd_chk(0, 3'd0, 16'hFFFF, 16'h0000, "arst_stat_ctrl");
        rd_chk(0, 3'd1, 16'hFFFF, 16'h0000, "arst_reload");
        rd_chk(0, 3'd2, 16'hFFFF, 16'h0000, "arst_t0");
        rd_chk(0, 3'd3, 16'hFFFF, 16'h0000, "arst_t1");
        rd_chk(0, 3'd4, 16'hFFFF, 16'h0000, "arst_t2");
        @(negedge clk);
        nReset = 1'b1;
        repeat (3) @(negedge clk);
        rd_chk(0, 3'd2, 16'hFFFF, 16'h0000, "presc_restart_hold");
        @(negedge clk);
        rd_chk(0, 3'd2, 16'hFFFF, 16'h0001, "presc_restart_tick");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
